// File: rtl/can_fifo_if.sv
// ---------------------------------------------------------------------------
// can_fifo_if
// Bundle of the data and status signals between the CAN FIFO and its user.
//   master : the user side. It drives the write/read requests and the write
//            data, and it observes the status flags and the read data.
//   slave  : the FIFO side. Its directions are the mirror of the master's.
// The clock and reset stay outside this bundle as plain module ports.
// ---------------------------------------------------------------------------
interface can_fifo_if #(
    parameter int DATA_WIDTH = 128
);
    logic                  i_wr_en;
    logic                  i_r_en;
    logic [DATA_WIDTH-1:0] i_fifo_w_data;
    logic                  o_empty;
    logic                  o_full;
    logic                  o_underflow;
    logic                  o_overflow;
    logic [DATA_WIDTH-1:0] o_fifo_r_data;

    modport master (
        output i_wr_en, i_r_en, i_fifo_w_data,
        input  o_empty, o_full, o_underflow, o_overflow, o_fifo_r_data
    );

    modport slave (
        input  i_wr_en, i_r_en, i_fifo_w_data,
        output o_empty, o_full, o_underflow, o_overflow, o_fifo_r_data
    );
endinterface

// File: rtl/can_fifo.sv
// ---------------------------------------------------------------------------
// can_fifo
// A single-clock FIFO that holds CAN frame words between the protocol engine
// and the host interface.
// Ports:
//   i_sys_clk : clock. All logic runs on the rising edge.
//   i_reset   : synchronous, active-high reset. It has priority over every
//               other input.
//   bus       : can_fifo_if.slave. It carries the write and read requests,
//               the write data, the registered read data, the empty and full
//               flags, and the one-cycle underflow and overflow pulses.
// An illegal access (a read while empty, or a write while full with no read
// on the same edge) is dropped. It raises its error pulse and leaves the
// pointers, the count and the data unchanged.
// ---------------------------------------------------------------------------
module can_fifo #(
    parameter int DATA_WIDTH = 128,
    parameter int DEPTH      = 8,
    parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic      i_sys_clk,
    input  logic      i_reset,
    can_fifo_if.slave bus
);
    localparam logic [ADDR_WIDTH:0] FULL_COUNT = (ADDR_WIDTH+1)'(DEPTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic [ADDR_WIDTH-1:0] wr_ptr_reg;
    logic [ADDR_WIDTH-1:0] rd_ptr_reg;
    logic [ADDR_WIDTH:0]   count_reg;
    logic [ADDR_WIDTH:0]   count_next;
    logic                  empty_reg;
    logic                  full_reg;
    logic                  underflow_reg;
    logic                  overflow_reg;
    logic [DATA_WIDTH-1:0] rd_data_reg;

    logic rd_accept;
    logic wr_accept;

    // A write is accepted while full only when a read frees the slot on the
    // same edge. When the FIFO is full, a read is always accepted.
    always_comb begin
        rd_accept  = bus.i_r_en && !empty_reg;
        wr_accept  = bus.i_wr_en && (!full_reg || rd_accept);
        count_next = count_reg;
        if (wr_accept && !rd_accept) begin
            count_next = count_reg + 1'b1;
        end else if (rd_accept && !wr_accept) begin
            count_next = count_reg - 1'b1;
        end
    end

    // The storage array has no reset, so it can map onto block RAM. A write
    // requested on a reset edge is suppressed here.
    always_ff @(posedge i_sys_clk) begin
        if (wr_accept && !i_reset) begin
            mem[wr_ptr_reg] <= bus.i_fifo_w_data;
        end
    end

    // On a full FIFO with read+write, wr_ptr == rd_ptr. The read below gets
    // the old word because the memory write above is non-blocking.
    always_ff @(posedge i_sys_clk) begin
        if (i_reset) begin
            wr_ptr_reg    <= '0;
            rd_ptr_reg    <= '0;
            count_reg     <= '0;
            empty_reg     <= 1'b1;
            full_reg      <= 1'b0;
            underflow_reg <= 1'b0;
            overflow_reg  <= 1'b0;
            rd_data_reg   <= '0;
        end else begin
            if (wr_accept) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (rd_accept) begin
                rd_data_reg <= mem[rd_ptr_reg];
                rd_ptr_reg  <= rd_ptr_reg + 1'b1;
            end
            count_reg     <= count_next;
            empty_reg     <= (count_next == '0);
            full_reg      <= (count_next == FULL_COUNT);
            underflow_reg <= bus.i_r_en && empty_reg;
            overflow_reg  <= bus.i_wr_en && full_reg && !rd_accept;
        end
    end

    assign bus.o_empty       = empty_reg;
    assign bus.o_full        = full_reg;
    assign bus.o_underflow   = underflow_reg;
    assign bus.o_overflow    = overflow_reg;
    assign bus.o_fifo_r_data = rd_data_reg;
endmodule

// File: tb/tb_can_fifo.sv
// ---------------------------------------------------------------------------
// tb_can_fifo
// Self-checking bench for can_fifo. The reference model is a queue of words
// that is updated once per clock edge from the FIFO access rules. A table of
// directed vectors with hand-derived expectations comes first. Hand-written
// sequences then cover fill/overflow, full read+write, wrap-around and a
// reset in the middle of operation. A randomized run ends the test.
// ---------------------------------------------------------------------------
module tb_can_fifo;
    localparam int DW    = 128;
    localparam int DEPTH = 8;

    logic i_sys_clk = 1'b0;
    logic i_reset;

    can_fifo_if #(.DATA_WIDTH(DW)) bus ();

    can_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
        .i_sys_clk (i_sys_clk),
        .i_reset   (i_reset),
        .bus       (bus.slave)
    );

    always #5 i_sys_clk = ~i_sys_clk;

    // Reference model state
    logic [DW-1:0] m_q [$];
    logic [DW-1:0] m_rdata;
    logic          m_uf;
    logic          m_of;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic          rst;
        logic          wr;
        logic          rd;
        logic [DW-1:0] wdata;
        logic          e_empty;
        logic          e_full;
        logic          e_uf;
        logic          e_of;
        logic [DW-1:0] e_rdata;
    } vec_t;

    vec_t tbl [12];

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Apply one cycle of stimulus, advance the model, and compare every output.
    task automatic step(input logic rst, input logic wr, input logic rd, input logic [DW-1:0] wdata);
        bit rd_ok;
        bit wr_ok;
        int sz;
        @(negedge i_sys_clk);
        i_reset           = rst;
        bus.i_wr_en       = wr;
        bus.i_r_en        = rd;
        bus.i_fifo_w_data = wdata;
        @(posedge i_sys_clk);
        sz = m_q.size();
        if (rst) begin
            m_q.delete();
            m_rdata = '0;
            m_uf    = 1'b0;
            m_of    = 1'b0;
        end else begin
            rd_ok = rd && (sz > 0);
            wr_ok = wr && ((sz < DEPTH) || rd_ok);
            m_uf  = rd && (sz == 0);
            m_of  = wr && (sz == DEPTH) && !rd_ok;
            if (rd_ok) m_rdata = m_q.pop_front();
            if (wr_ok) m_q.push_back(wdata);
        end
        #1;
        $display("t=%0t rst=%0b wr=%0b rd=%0b wd=%h -> e=%0b f=%0b uf=%0b of=%0b rd=%h",
                 $time, rst, wr, rd, wdata, bus.o_empty, bus.o_full,
                 bus.o_underflow, bus.o_overflow, bus.o_fifo_r_data);
        chk("empty",     DW'(bus.o_empty),     DW'(m_q.size() == 0));
        chk("full",      DW'(bus.o_full),      DW'(m_q.size() == DEPTH));
        chk("underflow", DW'(bus.o_underflow), DW'(m_uf));
        chk("overflow",  DW'(bus.o_overflow),  DW'(m_of));
        chk("rdata",     bus.o_fifo_r_data,    m_rdata);
    endtask

    logic [DW-1:0] w1, w2, w3, wff, wx;

    initial begin
        i_reset           = 1'b1;
        bus.i_wr_en       = 1'b0;
        bus.i_r_en        = 1'b0;
        bus.i_fifo_w_data = '0;
        m_rdata           = '0;
        m_uf              = 1'b0;
        m_of              = 1'b0;

        w1  = 128'h1;
        w2  = {16{8'h10}};
        w3  = '1;
        wff = {16{8'h11}};
        wx  = 128'hABCD;

        // Table:                rst wr rd data  empty full uf of rdata
        tbl[0]  = '{1'b0, 1'b1, 1'b0, w1,  1'b0, 1'b0, 1'b0, 1'b0, '0};
        tbl[1]  = '{1'b0, 1'b1, 1'b0, w2,  1'b0, 1'b0, 1'b0, 1'b0, '0};
        tbl[2]  = '{1'b0, 1'b1, 1'b0, w3,  1'b0, 1'b0, 1'b0, 1'b0, '0};
        tbl[3]  = '{1'b0, 1'b0, 1'b1, '0,  1'b0, 1'b0, 1'b0, 1'b0, w1};
        tbl[4]  = '{1'b0, 1'b0, 1'b1, '0,  1'b0, 1'b0, 1'b0, 1'b0, w2};
        tbl[5]  = '{1'b0, 1'b0, 1'b1, '0,  1'b1, 1'b0, 1'b0, 1'b0, w3};
        tbl[6]  = '{1'b0, 1'b0, 1'b1, '0,  1'b1, 1'b0, 1'b1, 1'b0, w3};
        tbl[7]  = '{1'b0, 1'b0, 1'b1, '0,  1'b1, 1'b0, 1'b1, 1'b0, w3};
        tbl[8]  = '{1'b0, 1'b0, 1'b0, '0,  1'b1, 1'b0, 1'b0, 1'b0, w3};
        tbl[9]  = '{1'b0, 1'b1, 1'b1, wx,  1'b0, 1'b0, 1'b1, 1'b0, w3};
        tbl[10] = '{1'b1, 1'b1, 1'b0, w1,  1'b1, 1'b0, 1'b0, 1'b0, '0};
        tbl[11] = '{1'b0, 1'b0, 1'b0, '0,  1'b1, 1'b0, 1'b0, 1'b0, '0};

        // Reset held for two cycles.
        step(1'b1, 1'b0, 1'b0, '0);
        step(1'b1, 1'b0, 1'b0, '0);

        // Directed vectors. Each row is also checked against the model.
        for (int i = 0; i < 12; i++) begin
            step(tbl[i].rst, tbl[i].wr, tbl[i].rd, tbl[i].wdata);
            chk($sformatf("tbl%0d_empty", i), DW'(bus.o_empty),     DW'(tbl[i].e_empty));
            chk($sformatf("tbl%0d_full", i),  DW'(bus.o_full),      DW'(tbl[i].e_full));
            chk($sformatf("tbl%0d_uf", i),    DW'(bus.o_underflow), DW'(tbl[i].e_uf));
            chk($sformatf("tbl%0d_of", i),    DW'(bus.o_overflow),  DW'(tbl[i].e_of));
            chk($sformatf("tbl%0d_rdata", i), bus.o_fifo_r_data,    tbl[i].e_rdata);
        end

        // Fill, then overflow, then drain.
        for (int i = 0; i < DEPTH; i++) begin
            step(1'b0, 1'b1, 1'b0, {4{32'hC0DE0000 + 32'(i)}});
        end
        chk("fill_full", DW'(bus.o_full), DW'(1));
        step(1'b0, 1'b1, 1'b0, wff);
        chk("ovf_pulse", DW'(bus.o_overflow), DW'(1));
        step(1'b0, 1'b0, 1'b0, '0);
        chk("ovf_cleared", DW'(bus.o_overflow), DW'(0));
        for (int i = 0; i < DEPTH; i++) begin
            step(1'b0, 1'b0, 1'b1, '0);
            chk("drain_word", bus.o_fifo_r_data, {4{32'hC0DE0000 + 32'(i)}});
        end
        chk("drain_empty", DW'(bus.o_empty), DW'(1));

        // Fill again, then read+write while full.
        for (int i = 0; i < DEPTH; i++) begin
            step(1'b0, 1'b1, 1'b0, {4{32'hBEEF0000 + 32'(i)}});
        end
        step(1'b0, 1'b1, 1'b1, wff);
        chk("full_rw_oldest", bus.o_fifo_r_data, {4{32'hBEEF0000}});
        chk("full_rw_stays_full", DW'(bus.o_full), DW'(1));
        chk("full_rw_no_ovf", DW'(bus.o_overflow), DW'(0));

        // Twenty alternating cycles, starting with a read, through pointer wrap.
        for (int i = 0; i < 20; i++) begin
            if (i % 2 == 0) step(1'b0, 1'b0, 1'b1, '0);
            else            step(1'b0, 1'b1, 1'b0, {4{32'h57A70000 + 32'(i)}});
        end

        // Reset in the middle of operation with five entries stored.
        step(1'b1, 1'b0, 1'b0, '0);
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 1'b1, 1'b0, {4{32'h5EED0000 + 32'(i)}});
        end
        step(1'b1, 1'b1, 1'b0, wx);
        chk("midrst_empty", DW'(bus.o_empty), DW'(1));
        chk("midrst_no_ovf", DW'(bus.o_overflow), DW'(0));
        step(1'b0, 1'b0, 1'b1, '0);
        chk("midrst_uf", DW'(bus.o_underflow), DW'(1));

        // Randomized traffic, with an occasional reset.
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 59) == 0),
                 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)),
                 {$urandom, $urandom, $urandom, $urandom});
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule

// File: doc/can_fifo.md
Name: can_fifo

Overview:
- Synchronous single-clock FIFO that buffers 128-bit CAN frame words between the CAN protocol engine and the host/bus interface of the CAN controller.
- Provides empty/full status and one-cycle error pulses for read-when-empty (underflow) and write-when-full (overflow).
- Illegal accesses are ignored without corrupting state.

Parameters:
- DATA_WIDTH, 128, width of each stored word and of both data ports.
- DEPTH, 8, number of entries; must be a power of two ≥ 2.
- ADDR_WIDTH, log2(DEPTH) = 3, pointer width; the occupancy counter is ADDR_WIDTH+1 bits.

Ports:
- i_sys_clk  in  1  system clock; all logic is on the rising edge.
- i_reset  in  1  reset, synchronous to i_sys_clk, active-high.
- i_wr_en  in  1  write request; sampled each rising edge.
- i_r_en  in  1  read request; sampled each rising edge.
- i_fifo_w_data  in  DATA_WIDTH  write data; captured on an edge where the write is accepted.
- o_empty  out  1  high when occupancy = 0 (registered).
- o_full  out  1  high when occupancy = DEPTH (registered).
- o_underflow  out  1  one-cycle pulse: read requested while empty.
- o_overflow  out  1  one-cycle pulse: write requested while full and not simultaneously read.
- o_fifo_r_data  out  DATA_WIDTH  read data (registered).

Behaviour:
Reset
- i_reset is sampled on a rising edge and has priority over everything else.
- On reset: write pointer = 0, read pointer = 0, count = 0, o_empty = 1, o_full = 0, o_underflow = 0, o_overflow = 0, o_fifo_r_data = 0.
- Memory contents are not cleared.
- Reset asserted mid-operation discards all stored entries on that edge. Any write or read requested on the same edge is ignored and raises no flag.

Write
- Accepted when i_wr_en = 1 and (o_full = 0, or a read is accepted on the same edge).
- On acceptance: mem[wr_ptr] <= i_fifo_w_data, then wr_ptr increments and wraps from DEPTH-1 to 0.

Read
- Accepted when i_r_en = 1 and o_empty = 0.
- On acceptance: o_fifo_r_data <= mem[rd_ptr], then rd_ptr increments and wraps.
- Latency: data is valid on o_fifo_r_data from the edge that accepts the read and is held until the next accepted read.

Occupancy and status
- Count goes +1 on write-only, -1 on read-only, and is unchanged when both a read and a write are accepted.
- o_empty and o_full are registered and reflect the count after each edge.
- Status changes are visible one cycle after the access that caused them.

Simultaneous read and write
- When empty: only the write is accepted. o_underflow pulses, and the count becomes 1 with o_empty = 0 on the next cycle.
- When full: both are accepted. The oldest word is output, the new word is stored, o_full stays 1, and o_overflow = 0.
- Otherwise both are accepted and the count is unchanged.

Error flags
- Registered; each is high for exactly the one cycle after the offending edge and 0 otherwise.
- Repeated illegal requests give continuous high while they persist.
- A rejected access changes no pointer, count or data.

Ordering and wrap-around
- Strict first-in first-out order is preserved across pointer wrap-around.

Test Plan:
- Reset check: hold i_reset = 1 for 2 cycles -> o_empty = 1, o_full = 0, o_underflow = 0, o_overflow = 0, o_fifo_r_data = 0.
- Write/read order: write 128'h…0001, 128'h1010…10, 128'hFFFF…FF on consecutive cycles, then read 3 times -> data out in that order; o_empty goes 0 after the first write and returns to 1 after the third read.
- Fill and overflow: write 8 distinct words -> o_full = 1; a 9th write of 128'h1111…11 -> o_overflow pulses for one cycle, contents unchanged, and reading 8 times returns the original 8 words.
- Underflow: read on an empty FIFO -> o_underflow pulses for one cycle, o_fifo_r_data holds its previous value, o_empty stays 1.
- Simultaneous access and wrap-around: with the FIFO full, read+write for one cycle -> oldest word out, o_full stays 1, no overflow. Then run 20 cycles of alternating write/read through pointer wrap -> FIFO order is preserved.
- Reset mid-operation: with 5 entries stored, assert i_reset together with i_wr_en = 1 -> o_empty = 1 and count = 0; a subsequent read gives an underflow pulse.
